// File: rtl/bf_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf_mult_pkg
// Description : Shared exception-flag bit positions and canonical NaN helper
//               for the approximate multiplier output path.
// Revision    : 1.0 - initial release
// ============================================================================
package bf_mult_pkg;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Quiet NaN {0, all-ones exponent, fraction MSB set}, right-aligned in 64 bits.
    function automatic logic [63:0] canonical_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_pack_pipe_rnd_unit.sv
`default_nettype none
// ============================================================================
// Module      : rnd_unit
// Description : Combinational rounding of a normalised fraction with LOW_W
//               extra bits; reports carry-out, kept fraction and inexact.
//               Rounding mode selected by ROUND_NEAREST_EN (truncate if unset).
// Revision    : 1.0 - initial release
// ============================================================================
module rnd_unit
    import bf_mult_pkg::*;
#(
    parameter int MAN_W = 7,
    parameter int LOW_W = 10
) (
    input  logic [MAN_W+LOW_W-1:0] i_man,
    output logic                   o_carry,
    output logic [MAN_W-1:0]       o_frac,
    output logic                   o_inexact
);

    logic             w_guard;
    logic             w_sticky;
    logic             w_inc;
    logic [MAN_W-1:0] w_kept;
    logic [MAN_W:0]   w_sum;

    assign w_guard  = i_man[LOW_W-1];
    assign w_sticky = |i_man[LOW_W-2:0];
    assign w_kept   = i_man[MAN_W+LOW_W-1:LOW_W];

`ifdef ROUND_NEAREST_EN
    logic w_lsb;
    assign w_lsb = i_man[LOW_W];
    assign w_inc = w_guard & (w_sticky | w_lsb);
`else
    assign w_inc = 1'b0;
`endif

    // A carry-out leaves the low MAN_W bits at zero, which is the required fraction.
    assign w_sum     = {1'b0, w_kept} + {{MAN_W{1'b0}}, w_inc};
    assign o_carry   = w_sum[MAN_W];
    assign o_frac    = w_sum[MAN_W-1:0];
    assign o_inexact = w_guard | w_sticky;

endmodule
`default_nettype wire

// File: rtl/round_pack_pipe.sv
`default_nettype none
// ============================================================================
// Module      : round_pack_pipe
// Description : Two-stage valid/ready round, classify and pack stage with
//               sticky exception flags. ROUND_NEAREST_EN selects RNE rounding.
// Revision    : 1.0 - initial release
// ============================================================================
module round_pack_pipe
    import bf_mult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int LOW_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+1:0]       in_exp,
    input  logic [MAN_W+LOW_W-1:0] in_man,
    input  logic                   in_sign,
    input  logic                   in_nan,
    input  logic                   in_inf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_word,
    output logic [3:0]             out_flags,
    output logic [3:0]             sticky_flags,
    input  logic                   flag_clr
);

    localparam int                      c_word_w    = 1 + EXP_W + MAN_W;
    localparam logic [63:0]             c_qnan_full = canonical_nan(EXP_W, MAN_W);
    localparam logic [c_word_w-1:0]     c_qnan      = c_qnan_full[c_word_w-1:0];
    localparam logic signed [EXP_W+1:0] c_exp_ovf   = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EXP_W+1:0] c_exp_zero  = '0;

    logic                    w_carry;
    logic [MAN_W-1:0]        w_frac;
    logic                    w_inexact;
    logic [EXP_W+1:0]        w_rnd_exp;
    logic                    w_s1_load;
    logic                    w_s2_load;
    logic                    w_xfer;
    logic [c_word_w-1:0]     w_word;
    logic [3:0]              w_flags;

    logic                    r_s1_valid;
    logic signed [EXP_W+1:0] r_s1_exp;
    logic [MAN_W-1:0]        r_s1_frac;
    logic                    r_s1_sign;
    logic                    r_s1_nan;
    logic                    r_s1_inf;
    logic                    r_s1_inexact;
    logic                    r_s1_nz;
    logic                    r_s2_valid;
    logic [c_word_w-1:0]     r_out_word;
    logic [3:0]              r_out_flags;
    logic [3:0]              r_sticky;

    rnd_unit #(
        .MAN_W (MAN_W),
        .LOW_W (LOW_W)
    ) u_rnd (
        .i_man     (in_man),
        .o_carry   (w_carry),
        .o_frac    (w_frac),
        .o_inexact (w_inexact)
    );

    // Stage 1 may refill whenever its content moves on or it is empty.
    assign w_s2_load = !r_s2_valid | out_ready;
    assign w_s1_load = !r_s1_valid | w_s2_load;
    assign in_ready  = w_s1_load;
    assign w_xfer    = r_s2_valid & out_ready;
    assign w_rnd_exp = in_exp + {{(EXP_W+1){1'b0}}, w_carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_frac    <= '0;
            r_s1_sign    <= 1'b0;
            r_s1_nan     <= 1'b0;
            r_s1_inf     <= 1'b0;
            r_s1_inexact <= 1'b0;
            r_s1_nz      <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_exp     <= w_rnd_exp;
                r_s1_frac    <= w_frac;
                r_s1_sign    <= in_sign;
                r_s1_nan     <= in_nan;
                r_s1_inf     <= in_inf;
                r_s1_inexact <= w_inexact;
                r_s1_nz      <= |in_man;
            end
        end
    end

    always_comb begin
        w_word                = {r_s1_sign, r_s1_exp[EXP_W-1:0], r_s1_frac};
        w_flags               = '0;
        w_flags[FLAG_INEXACT] = r_s1_inexact;
        if (r_s1_nan) begin
            w_word                = c_qnan;
            w_flags               = '0;
            w_flags[FLAG_INVALID] = 1'b1;
        end else if (r_s1_inf) begin
            w_word  = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags = '0;
        end else if (r_s1_exp >= c_exp_ovf) begin
            w_word                 = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags[FLAG_OVERFLOW] = 1'b1;
            w_flags[FLAG_INEXACT]  = 1'b1;
        end else if (r_s1_exp <= c_exp_zero) begin
            w_word                  = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
            w_flags[FLAG_UNDERFLOW] = 1'b1;
            w_flags[FLAG_INEXACT]   = r_s1_nz;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_out_word  <= '0;
            r_out_flags <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_word  <= w_word;
                r_out_flags <= w_flags;
            end
        end
    end

    // A clear coinciding with a transfer keeps only that transfer's flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= '0;
        end else if (flag_clr) begin
            r_sticky <= w_xfer ? r_out_flags : 4'b0000;
        end else if (w_xfer) begin
            r_sticky <= r_sticky | r_out_flags;
        end
    end

    assign out_valid    = r_s2_valid;
    assign out_word     = r_out_word;
    assign out_flags    = r_out_flags;
    assign sticky_flags = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_round_pack_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_pack_pipe
// Description : Randomised self-checking bench for round_pack_pipe against a
//               queue-based arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_pack_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_exp;
    logic [16:0] in_man;
    logic        in_sign;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic [3:0]  out_flags;
    logic [3:0]  sticky_flags;
    logic        flag_clr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [19:0] exp_q[$];
    logic [3:0]  m_sticky;
    bit          hold_pending;
    logic [15:0] held_word;
    logic [3:0]  held_flags;
    bit          last_in_ready;
    bit          last_out_valid;
    logic [15:0] last_out_word;
    logic [3:0]  last_out_flags;

    round_pack_pipe #(.EXP_W(8), .MAN_W(7), .LOW_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_exp       (in_exp),
        .in_man       (in_man),
        .in_sign      (in_sign),
        .in_nan       (in_nan),
        .in_inf       (in_inf),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .flag_clr     (flag_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    // Returns {flags, word}; rounding done on integer value and remainder.
    function automatic logic [19:0] ref_model(int e, int man, bit s, bit nan, bit inf);
        int       kept;
        int       rem;
        bit       inx;
        logic [15:0] w;
        logic [3:0]  f;
        kept = man >> 10;
        rem  = man % 1024;
        inx  = (rem != 0);
`ifdef ROUND_NEAREST_EN
        if (rem > 512 || (rem == 512 && (kept % 2) == 1)) kept = kept + 1;
`endif
        if (kept == 128) begin
            kept = 0;
            e    = e + 1;
        end
        if (nan) begin
            w = {1'b0, 8'hFF, 7'h40};  f = 4'b1000;
        end else if (inf) begin
            w = {s, 8'hFF, 7'h00};     f = 4'b0000;
        end else if (e >= 255) begin
            w = {s, 8'hFF, 7'h00};     f = 4'b0101;
        end else if (e <= 0) begin
            w = {s, 15'h0000};         f = {3'b001, man != 0};
        end else begin
            w = {s, 8'(e), 7'(kept)};  f = {3'b000, inx};
        end
        return {f, w};
    endfunction

    // One clock: drive, settle, score outputs/handshakes, then step the edge.
    task automatic cycle(input bit iv, input bit ordy, input bit clr);
        logic [19:0] e;
        logic [3:0]  xf;
        in_valid  = iv;
        out_ready = ordy;
        flag_clr  = clr;
        #1;
        last_in_ready  = in_ready;
        last_out_valid = out_valid;
        last_out_word  = out_word;
        last_out_flags = out_flags;
        check_val("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || ordy));
        if (hold_pending) begin
            check_val("hold_valid", 32'(out_valid), 32'd1);
            check_val("hold_word", 32'(out_word), 32'(held_word));
            check_val("hold_flags", 32'(out_flags), 32'(held_flags));
        end
        hold_pending = out_valid && !ordy;
        held_word    = out_word;
        held_flags   = out_flags;
        xf = 4'b0000;
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("out_word", 32'(out_word), 32'(e[15:0]));
                check_val("out_flags", 32'(out_flags), 32'(e[19:16]));
                xf = e[19:16];
            end
        end
        m_sticky = clr ? xf : (m_sticky | xf);
        if (iv && in_ready)
            exp_q.push_back(ref_model(int'($signed(in_exp)), int'(in_man), in_sign, in_nan, in_inf));
        @(posedge clk);
        #1;
        check_val("sticky", 32'(sticky_flags), 32'(m_sticky));
    endtask

    task automatic set_in(input logic [9:0] e, input logic [16:0] m, input bit s, input bit nan, input bit inf);
        in_exp = e; in_man = m; in_sign = s; in_nan = nan; in_inf = inf;
    endtask

    task automatic directed(input string tag, input logic [9:0] e, input logic [16:0] m, input bit s,
                            input bit nan, input bit inf, input logic [15:0] ew, input logic [3:0] ef);
        set_in(e, m, s, nan, inf);
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        check_val({tag, "_lat1"}, 32'(last_out_valid), 32'd0);
        cycle(0, 1, 0);
        check_val({tag, "_lat2"}, 32'(last_out_valid), 32'd1);
        check_val({tag, "_word"}, 32'(last_out_word), 32'(ew));
        check_val({tag, "_flags"}, 32'(last_out_flags), 32'(ef));
    endtask

    task automatic rand_in();
        int          e;
        logic [16:0] m;
        case ($urandom_range(0, 3))
            0:       e = int'($urandom_range(1, 254));
            1:       e = int'($urandom_range(248, 262));
            2:       e = int'($urandom_range(0, 8)) - 4;
            default: e = int'($urandom_range(0, 1022)) - 512;
        endcase
        m = 17'($urandom_range(0, 17'h1FFFF));
        case ($urandom_range(0, 5))
            0: m[9:0] = 10'h200;
            1: m = 17'h1FE00 | 17'($urandom_range(0, 511));
            2: m = 17'h0;
            default: ;
        endcase
        set_in(10'(e), m, 1'($urandom_range(0, 1)),
               $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
        set_in(10'd0, 17'd0, 1'b0, 1'b0, 1'b0);
        m_sticky = 4'b0000; hold_pending = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_word", 32'(out_word), 32'd0);
        check_val("rst_out_flags", 32'(out_flags), 32'd0);
        check_val("rst_sticky", 32'(sticky_flags), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        directed("normal", 10'd127, 17'h10000, 1'b0, 1'b0, 1'b0, 16'h3FC0, 4'b0000);
`ifdef ROUND_NEAREST_EN
        directed("round", 10'd127, 17'h1FE00, 1'b0, 1'b0, 1'b0, 16'h4000, 4'b0001);
`else
        directed("round", 10'd127, 17'h1FE00, 1'b0, 1'b0, 1'b0, 16'h3FFF, 4'b0001);
`endif
        directed("tie_even", 10'd127, 17'h10200, 1'b0, 1'b0, 1'b0, 16'h3FC0, 4'b0001);
        directed("overflow", 10'd300, 17'h10000, 1'b1, 1'b0, 1'b0, 16'hFF80, 4'b0101);
        directed("underflow", 10'h3FD, 17'h00000, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0010);
        directed("nan", 10'd127, 17'h10000, 1'b1, 1'b1, 1'b0, 16'h7FC0, 4'b1000);
        directed("inf", 10'd5, 17'h10000, 1'b1, 1'b0, 1'b1, 16'hFF80, 4'b0000);

        // Backpressure: three words offered while the consumer stalls.
        cycle(0, 1, 1);
        set_in(10'd300, 17'h10000, 1'b1, 1'b0, 1'b0);
        cycle(1, 0, 0);
        set_in(10'h3FD, 17'h00400, 1'b0, 1'b0, 1'b0);
        cycle(1, 0, 0);
        set_in(10'd127, 17'h10000, 1'b0, 1'b1, 1'b0);
        cycle(1, 0, 0);
        check_val("bp_ready_drop", 32'(last_in_ready), 32'd0);
        cycle(1, 1, 0);
        check_val("bp_first", 32'(last_out_word), 32'hFF80);
        cycle(0, 1, 0);
        check_val("bp_second", 32'(last_out_word), 32'h0000);
        check_val("bp_sticky_or", 32'(sticky_flags), 32'b0111);
        cycle(0, 1, 1);
        check_val("bp_third", 32'(last_out_word), 32'h7FC0);
        check_val("bp_clr_xfer", 32'(sticky_flags), 32'b1000);

        // Mid-operation reset discards both stages.
        rand_in();
        cycle(1, 0, 0);
        rand_in();
        cycle(1, 0, 0);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete(); m_sticky = 4'b0000; hold_pending = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_ready", 32'(in_ready), 32'd1);
        check_val("mid_rst_sticky", 32'(sticky_flags), 32'd0);

        for (int i = 0; i < 2000; i++) begin
            rand_in();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(0, 1, 0);
        check_val("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
